// File: rtl/onchip_memory_ctrl.sv
// onchip_memory_ctrl
//   Avalon-MM slave in front of an inferred single-port RAM. It serves as
//   instruction/data memory for the soft CPU. Features: byte-lane writes,
//   pipelined reads with a latency of 1 or 2, an optional engine that zeroes
//   the RAM after reset, and a pulse that flags accesses beyond DEPTH.
//
// Ports
//   clk, reset_n   clock and asynchronous active-low reset
//   address        word address (ADDR_WIDTH)
//   byteenable     byte lane enables for writes (DATA_WIDTH/8)
//   chipselect     slave select
//   read, write    request strobes; write wins when both are high
//   writedata      write data
//   clken          clock enable; when low, the pipeline and the clear engine freeze
//   readdata       read data, qualified by readdatavalid and held otherwise
//   readdatavalid  one pulse per accepted read
//   waitrequest    high while a request cannot be accepted
//   init_done      high once the clear engine has finished (sticky)
//   bad_access     one-cycle pulse after an accepted access with address >= DEPTH
module onchip_memory_ctrl #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 16,
  parameter int    DEPTH          = 40960,
  parameter int    READ_LATENCY   = 2,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "onchip_memory.hex"
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  output logic                      init_done,
  output logic                      bad_access
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  // The RAM image is handed to the FPGA flow through the ram_init_file
  // attribute. Simulation starts from whatever the RAM model holds.
  if (INIT_FILE != "") begin : g_init_image
  end

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           state;
  logic             wait_q;
  logic [IDX_W-1:0] clear_addr;

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             acc;
  logic             wr_acc;
  logic             rd_acc;
  logic             clr_we;

  // Only the low index bits address the array. Out-of-range accesses are
  // masked by in_range, so aliased words are never touched.
  assign idx      = address[IDX_W-1:0];
  assign in_range = (33'(address) < 33'(DEPTH));

  assign waitrequest = wait_q | ~clken;
  assign acc         = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = chipselect & write & ~waitrequest;
  // A write takes priority, so a simultaneous read is dropped.
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign clr_we      = (state == S_CLEAR) & clken;

  // ---------------------------------------------------------------- RAM
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clear_addr] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      wait_q     <= 1'b1;
      init_done  <= 1'b0;
      clear_addr <= '0;
    end else if (clken) begin
      case (state)
        S_CLEAR: begin
          if (clear_addr == LAST) begin
            state      <= S_IDLE;
            wait_q     <= 1'b0;
            init_done  <= 1'b1;
            clear_addr <= '0;
          end else begin
            clear_addr <= clear_addr + 1'b1;
          end
        end
        default: begin
          wait_q    <= 1'b0;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // ----------------------------------------------------- read pipeline
  // Stage 1 is the RAM read register. Any later stages are output registers.
  // A data stage only loads alongside a valid bit, so readdata holds its
  // last value between results.
  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] data_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else if (clken) begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) data_pipe[1] <= in_range ? mem[idx] : '0;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign readdata = data_pipe[READ_LATENCY];
  // A held result is masked while frozen. It presents once clken returns.
  assign readdatavalid = vld_pipe[READ_LATENCY] & clken;

  // Acceptance already implies clken, so this pulse needs no enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bad_access <= 1'b0;
    else          bad_access <= acc & ~in_range;
  end

endmodule

// File: tb/tb_onchip_memory_ctrl.sv
// Bench for onchip_memory_ctrl. Two instances share every input:
// dut 0 has READ_LATENCY=2 and dut 1 has READ_LATENCY=1. Stimulus pushes the
// expected read data and the enabled-cycle index at which each result is due.
// A monitor pops those entries whenever a DUT presents readdatavalid or
// bad_access.
module tb_onchip_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write, clken;
  logic [31:0] writedata;

  logic [31:0] rdd [2];
  logic        rdv [2];
  logic        wrq [2];
  logic        idn [2];
  logic        bad [2];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_rd  [2][$];
  int   q_bad [2][$];
  int   bad_seen [2];
  int   en_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  int   mon_d;

  always #5 clk = ~clk;

  onchip_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16),
                       .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdd[0]), .readdatavalid(rdv[0]),
    .waitrequest(wrq[0]), .init_done(idn[0]), .bad_access(bad[0]));

  onchip_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdd[1]), .readdatavalid(rdv[1]),
    .waitrequest(wrq[1]), .init_done(idn[1]), .bad_access(bad[1]));

  // Latency is counted in enabled edges.
  always @(posedge clk) if (clken) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // ------------------------------------------------------------ monitor
  always begin
    @(negedge clk); #2;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rdv[i]) begin
          checks++;
          if (q_rd[i].size() == 0) begin
            errors++;
            $display("FAIL rdv_spurious dut%0d actual data=%h expected no result", i, rdd[i]);
          end else begin
            mon_e = q_rd[i].pop_front();
            if (rdd[i] !== mon_e.data || en_cnt != mon_e.due) begin
              errors++;
              $display("FAIL read_result dut%0d actual data=%h cyc=%0d expected data=%h cyc=%0d",
                       i, rdd[i], en_cnt, mon_e.data, mon_e.due);
            end
          end
        end else if (q_rd[i].size() != 0 && q_rd[i][0].due < en_cnt) begin
          checks++;
          errors++;
          mon_e = q_rd[i].pop_front();
          $display("FAIL read_late dut%0d actual none at cyc=%0d expected data=%h at cyc=%0d",
                   i, en_cnt, mon_e.data, mon_e.due);
        end
        if (bad[i]) begin
          bad_seen[i]++;
          checks++;
          if (q_bad[i].size() == 0) begin
            errors++;
            $display("FAIL bad_spurious dut%0d actual pulse at cyc=%0d expected none", i, en_cnt);
          end else begin
            mon_d = q_bad[i].pop_front();
            if (en_cnt != mon_d) begin
              errors++;
              $display("FAIL bad_timing dut%0d actual cyc=%0d expected cyc=%0d", i, en_cnt, mon_d);
            end
          end
        end
        if (!clken) begin
          checks++;
          if (rdv[i] !== 1'b0 || wrq[i] !== 1'b1) begin
            errors++;
            $display("FAIL stall dut%0d actual rdv=%b wait=%b expected rdv=0 wait=1", i, rdv[i], wrq[i]);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic req(input logic w, input logic r, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] expv);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    chipselect = 1'b1; read = r; write = w; address = a; writedata = wd; byteenable = be;
    #1;
    while ((wrq[0] | wrq[1]) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h actual waitrequest=1 expected 0", a);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r && !w) begin
          e.data = expv;
          e.due  = en_cnt + ((i == 0) ? 2 : 1);
          q_rd[i].push_back(e);
        end
        if (a >= 8'd16) q_bad[i].push_back(en_cnt + 1);
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    req(1'b1, 1'b0, a, d, be, 32'h0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] expv);
    req(1'b0, 1'b1, a, 32'h0, 4'h0, expv);
  endtask

  task automatic drain();
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic release_and_count(input string tag);
    int   cnt  = 0;
    logic seen = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    while ((wrq[0] | wrq[1]) && cnt < 100) begin
      cnt++;
      if (idn[0] | idn[1]) seen = 1'b1;
      @(negedge clk); #2;
    end
    chk({tag, "_wait_cycles"}, 32'(cnt), 32'd16);
    chk({tag, "_init_early"}, {31'd0, seen}, 32'd0);
    chk({tag, "_init_done0"}, {31'd0, idn[0]}, 32'd1);
    chk({tag, "_init_done1"}, {31'd0, idn[1]}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b1; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    bad_seen[0] = 0; bad_seen[1] = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_readdata%0d", i), rdd[i], 32'h0);
      chk($sformatf("rst_rdv%0d", i), {31'd0, rdv[i]}, 32'd0);
      chk($sformatf("rst_wait%0d", i), {31'd0, wrq[i]}, 32'd1);
      chk($sformatf("rst_init%0d", i), {31'd0, idn[i]}, 32'd0);
      chk($sformatf("rst_bad%0d", i), {31'd0, bad[i]}, 32'd0);
    end

    release_and_count("clear1");

    // Fill the RAM, then read it back with back-to-back reads.
    for (int i = 0; i < 16; i++) wr(8'(i), 32'hA5A5_0000 | i, 4'hF);
    for (int i = 0; i < 16; i++) rd(8'(i), 32'hA5A5_0000 | i);
    drain();

    // Byte-lane merge.
    wr(8'd3, 32'hAABB_CCDD, 4'b1111);
    wr(8'd3, 32'h1122_3344, 4'b0101);
    rd(8'd3, 32'hAA22_CC44);
    drain();

    // A read on the cycle after a write returns the new data.
    wr(8'd5, 32'h1234_5678, 4'hF);
    rd(8'd5, 32'h1234_5678);
    wr(8'd5, 32'hFFFF_0000, 4'b1100);
    rd(8'd5, 32'hFFFF_5678);
    // With read and write together, the write happens and no result is produced.
    req(1'b1, 1'b1, 8'd6, 32'h0000_0066, 4'hF, 32'h0);
    rd(8'd6, 32'h0000_0066);
    drain();

    // Pipelined reads of a small ramp.
    for (int i = 0; i < 4; i++) wr(8'(i), 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) rd(8'(i), 32'(i));
    drain();

    // Freeze for three cycles, starting one cycle after a read is accepted.
    rd(8'd2, 32'd2);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; clken = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    clken = 1'b1;
    drain();

    // Out of range: addr 20 must not alias onto addr 4.
    wr(8'd4, 32'h4444_4444, 4'hF);
    wr(8'd20, 32'hDEAD_BEEF, 4'hF);
    rd(8'd20, 32'h0);
    rd(8'd4, 32'h4444_4444);
    drain();
    chk("bad_pulses0", 32'(bad_seen[0]), 32'd2);
    chk("bad_pulses1", 32'(bad_seen[1]), 32'd2);

    // Nonzero contents, then a reset that interrupts the clear at cycle 8.
    for (int i = 0; i < 16; i++) wr(8'(i), 32'h5A5A_0000 | i, 4'hF);
    drain();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    release_and_count("clear2");
    for (int i = 0; i < 16; i++) rd(8'(i), 32'h0);
    drain();

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_queue_empty%0d", i), 32'(q_rd[i].size()), 32'd0);
      chk($sformatf("bad_queue_empty%0d", i), 32'(q_bad[i].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
